// File: rtl/hidden_wires_pkg.sv
// Shared types for the hidden-wires debug channel: the producer bus and the
// trace record kept by the sink (the bus minus its enable strobe).
package hidden_wires_pkg;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] data;
    logic [63:0] data64;
    logic        enable;
  } hidden_wires_t;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] data;
    logic [63:0] data64;
  } hidden_wires_trace_t;

  localparam int TRACE_W = $bits(hidden_wires_trace_t);

  function automatic hidden_wires_trace_t to_trace(input hidden_wires_t hw);
    hidden_wires_trace_t rec;
    rec.address = hw.address;
    rec.data    = hw.data;
    rec.data64  = hw.data64;
    return rec;
  endfunction

endpackage

// File: rtl/hidden_wires_fifo.sv
// Generic synchronous show-ahead FIFO: dout always shows the head entry.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module hidden_wires_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A pop at full frees the slot being written, so the push may proceed.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hidden_wires_sink.sv
// Consumer end of the hidden-wires channel: captures enabled transfers inside
// the address window into a FIFO; overflow is counted since the producer cannot stall.
module hidden_wires_sink
  import hidden_wires_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [63:0] ADDR_LO = 64'h0,
  parameter logic [63:0] ADDR_HI = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          DROP_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  hidden_wires_t           hw_in,
  input  logic                    clear_drops,
  output logic                    out_valid,
  input  logic                    out_ready,
  output hidden_wires_trace_t     out_rec,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [DROP_W-1:0]       drop_count
);

  logic lo_ok;
  logic hi_ok;
  logic hit;
  logic pop;
  logic push;
  logic drop;
  logic full;
  logic empty;
  logic [TRACE_W-1:0] head;

  // Open-ended window bounds would give constant compares, so they are elided.
  if (ADDR_LO == 64'h0) begin : g_lo_open
    assign lo_ok = 1'b1;
  end else begin : g_lo_cmp
    assign lo_ok = (hw_in.address >= ADDR_LO);
  end

  if (ADDR_HI == 64'hFFFF_FFFF_FFFF_FFFF) begin : g_hi_open
    assign hi_ok = 1'b1;
  end else begin : g_hi_cmp
    assign hi_ok = (hw_in.address <= ADDR_HI);
  end

  // NOTE: every signal written here is assigned on every path, so no latch is inferred.
  always_comb begin
    hit  = hw_in.enable && lo_ok && hi_ok;
    pop  = out_valid && out_ready;
    push = hit && (!full || pop);
    drop = hit && full && !pop;
  end

  hidden_wires_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (to_trace(hw_in)),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign out_valid = !empty;
  assign out_rec   = hidden_wires_trace_t'(head);

  // A clear coinciding with a drop keeps that drop rather than losing it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (clear_drops) begin
      drop_count <= drop ? DROP_W'(1) : '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hidden_wires_sink.sv
// Directed bench for hidden_wires_sink: a vector table for filtering/latency,
// then hand-written sequences for overflow, full push+pop, counter edges and reset.
module tb_hidden_wires_sink;
  import hidden_wires_pkg::*;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int DW    = 4;

  logic                 clk;
  logic                 reset;
  hidden_wires_t        hw_in;
  logic                 clear_drops;
  logic                 out_valid;
  logic                 out_ready;
  hidden_wires_trace_t  out_rec;
  logic [LW-1:0]        fifo_level;
  logic [DW-1:0]        drop_count;

  int n_cmp  = 0;
  int n_fail = 0;

  hidden_wires_sink #(
    .DEPTH   (DEPTH),
    .ADDR_LO (64'h1000),
    .ADDR_HI (64'h1FFF),
    .DROP_W  (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hw_in       (hw_in),
    .clear_drops (clear_drops),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rec     (out_rec),
    .fifo_level  (fifo_level),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [63:0] addr;
    logic [31:0] data;
    logic        ready;
    logic        clr;
    logic        exp_valid;
    logic [3:0]  exp_level;
    logic [3:0]  exp_drops;
    logic        chk_rec;
    logic [63:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [63:0] d64(input logic [31:0] d);
    return {~d, d};
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic en, input logic [63:0] addr, input logic [31:0] data,
                       input logic ready, input logic clr);
    hw_in.enable  = en;
    hw_in.address = addr;
    hw_in.data    = data;
    hw_in.data64  = d64(data);
    out_ready     = ready;
    clear_drops   = clr;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic v, input logic [3:0] lvl,
                             input logic [3:0] drp);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".level"}, 64'(fifo_level), 64'(lvl));
    check({tag, ".drops"}, 64'(drop_count), 64'(drp));
  endtask

  logic [31:0] drain_exp[8];

  initial begin
    // Window filter then capture latency / hold behaviour.
    vecs[0] = '{1'b1, 64'h0FFF, 32'h1,        1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 64'h0,    32'h0};
    vecs[1] = '{1'b1, 64'h1000, 32'h2,        1'b1, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 64'h1000, 32'h2};
    vecs[2] = '{1'b1, 64'h1FFF, 32'h3,        1'b1, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 64'h1FFF, 32'h3};
    vecs[3] = '{1'b1, 64'h2000, 32'h4,        1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 64'h0,    32'h0};
    vecs[4] = '{1'b0, 64'h1500, 32'h5,        1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 64'h0,    32'h0};
    vecs[5] = '{1'b1, 64'h1234, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 64'h1234, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 64'h1234, 32'h0,        1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 64'h1234, 32'hDEADBEEF};
    vecs[7] = '{1'b0, 64'h0,    32'h0,        1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 64'h0,    32'h0};
    drain_exp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd100};

    reset = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    #3;
    check_state("reset", 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].en, vecs[i].addr, vecs[i].data, vecs[i].ready, vecs[i].clr);
      tick();
      check_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_level, vecs[i].exp_drops);
      if (vecs[i].chk_rec) begin
        check($sformatf("vec%0d.addr", i), out_rec.address, vecs[i].exp_addr);
        check($sformatf("vec%0d.data", i), 64'(out_rec.data), 64'(vecs[i].exp_data));
        check($sformatf("vec%0d.data64", i), out_rec.data64, d64(vecs[i].exp_data));
      end
    end

    // Overflow: 11 hits into an 8-deep FIFO with the consumer stalled.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 64'h1000 + 64'(i), 32'(i), 1'b0, 1'b0);
      tick();
    end
    check_state("ovf", 1'b1, 4'd8, 4'd3);
    check("ovf.head", 64'(out_rec.data), 64'd0);

    // Full with simultaneous push and pop: hit accepted, no drop.
    drive(1'b1, 64'h1100, 32'd100, 1'b1, 1'b0);
    check("pp.popped", 64'(out_rec.data), 64'd0);
    tick();
    check_state("pp", 1'b1, 4'd8, 4'd3);

    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      check($sformatf("drain%0d.data", i), 64'(out_rec.data), 64'(drain_exp[i]));
      tick();
    end
    check_state("drained", 1'b0, 4'd0, 4'd3);

    // Saturation: refill, then 20 more hits while full.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'h1800, 32'd200 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    check_state("refill", 1'b1, 4'd8, 4'd3);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 64'h1801, 32'hFFFF, 1'b0, 1'b0);
      tick();
    end
    check("sat.drops", 64'(drop_count), 64'd15);

    // Clear coinciding with a drop, then plain drop, plain clear, drop again.
    drive(1'b1, 64'h1801, 32'hFFFF, 1'b0, 1'b1);
    tick();
    check("clr_drop.drops", 64'(drop_count), 64'd1);
    drive(1'b1, 64'h1801, 32'hFFFF, 1'b0, 1'b0);
    tick();
    check("drop2.drops", 64'(drop_count), 64'd2);
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
    tick();
    check("clr.drops", 64'(drop_count), 64'd0);
    drive(1'b1, 64'h1801, 32'hFFFF, 1'b0, 1'b0);
    tick();
    check("drop3.drops", 64'(drop_count), 64'd1);

    // Reset mid-drain with five entries held.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      tick();
    end
    check_state("middrain", 1'b1, 4'd5, 4'd1);
    check("middrain.head", 64'(out_rec.data), 64'd203);
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check_state("async_rst", 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 64'h1ABC, 32'h55AA, 1'b0, 1'b0);
    tick();
    check_state("post_rst", 1'b1, 4'd1, 4'd0);
    check("post_rst.data", 64'(out_rec.data), 64'h55AA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
